addsub_pipe: RTL and testbench
==============================

Name: addsub_pipe

Overview:
- Parametrised pipelined adder/subtractor.
- Splits a WIDTH-bit add into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages.
- Accepts one operation per cycle over a valid/ready handshake.
- Datapath building block for the processor ALU and accumulator blocks, where a single-cycle WIDTH-bit ripple carry would limit clock rate.

Parameters:
- WIDTH, 16, operand and result width in bits.
- CHUNK, 4, bits summed per stage. WIDTH must be an exact multiple of CHUNK.
- STAGES, WIDTH/CHUNK, derived (localparam): pipeline depth and latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation present on a, b, c_in, sub.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present on sum, c_out, ovf.
- out_ready  input  1  downstream consumes the result this cycle.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of the MSB.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Operation definition:
  - b_eff = sub ? ~b : b
  - cin_eff = sub ? ~c_in : c_in
  - {c_out, sum} = a + b_eff + cin_eff, computed modulo 2^(WIDTH+1).
  - In subtract mode this gives a - b - c_in. c_out=1 means no borrow.
- ovf = (a[MSB] == b_eff[MSB]) && (raw_sum[MSB] != a[MSB]).
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b_eff plus the carry registered by stage k-1; stage 0 uses cin_eff.
  - Forwards the lower sum chunks already produced.
  - Forwards the still-unsummed upper operand chunks (skewed delay).
  - Forwards a valid bit.
- Latency: an operation accepted at edge N appears with out_valid=1 after edge N+STAGES-1. Throughput is 1 op/cycle.
- Handshake:
  - stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - When not stalled, all stages advance on each edge.
  - When stalled, all stage registers hold, including bubbles.
  - Accept occurs on in_valid && in_ready.
  - Consume occurs on out_valid && out_ready.
  - A simultaneous accept and consume in one cycle is legal and loses nothing.
  - in_valid with in_ready=0 is ignored. The source must hold its data.
- Bubbles: an invalid slot propagates with valid=0. Its data is don't-care, but out_valid must never assert for it.
- Ordering: results leave strictly in acceptance order, with no duplication or loss.
- Reset (rst_n=0, takes effect immediately):
  - All valid bits, data registers and carries clear to 0.
  - Outputs: out_valid=0, sum=0, c_out=0, ovf=0.
  - in_ready=1 once out_valid=0.
  - In-flight operations are discarded and never emerge after release.
- Wrap-around: without the optional feature, the result wraps modulo 2^WIDTH; c_out and ovf report the event.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined:
  - When ovf=1, sum saturates to signed max (0111..1) if a[MSB]=0, or signed min (1000..0) if a[MSB]=1.
  - ovf is still asserted.
  - c_out is unchanged (raw carry).
  - Latency is unchanged; saturation is applied in the final stage.
- Undefined: sum is the raw wrapped result and no saturation logic is generated.

Test Plan (WIDTH=16, CHUNK=4, latency 4):
1. Reset with rst_n=0 for 2 cycles -> out_valid=0, sum=0x0000, c_out=0, ovf=0, in_ready=1.
2. Cross-chunk carry: add a=0x00FF, b=0x0001, c_in=0 -> 4 cycles later sum=0x0100, c_out=0, ovf=0.
3. Unsigned wrap and signed overflow:
   - a=0xFFFF, b=0x0001 -> sum=0x0000, c_out=1, ovf=0.
   - a=0x7FFF, b=0x0001 -> ovf=1, sum=0x8000 (0x7FFF with ADDSUB_SAT_EN).
4. Subtract: sub=1, a=0x0005, b=0x0007, c_in=0 -> sum=0xFFFE, c_out=0, ovf=0.
   - Then a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1 (0x8000 with ADDSUB_SAT_EN).
5. Back-pressure: 8 back-to-back random ops with out_ready toggling 1,0,0,1... -> all 8 results match the reference model in order; in_ready=0 exactly when out_valid=1 and out_ready=0; stalled outputs are held stable.
6. Mid-stream reset: pulse rst_n low for half a cycle with 3 ops in flight -> out_valid drops immediately; no result appears after release; the next op accepted afterwards completes in 4 cycles.

Source files
------------

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice per stage, with the carry registered between stages.
// Define ADDSUB_SAT_EN to saturate the sum to signed max/min on overflow. Without it, the result wraps.
module addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int MSB    = WIDTH - 1;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cy_q, cy_d;
  logic [STAGES-1:0] cin_k;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [CHUNK:0]    part [STAGES];
  logic              ovf_q, ovf_d;
  logic              stall;

  // The whole pipe freezes as one unit, so a held result never gets overwritten.
  assign stall    = vld_q[STAGES-1] && !out_ready;
  assign in_ready = !stall;

  // NOTE: every always_comb output is given a value on every path before use, so no latch is inferred.
  always_comb begin
    vld_d[0] = in_valid;
    a_d[0]   = a;
    b_d[0]   = sub ? ~b : b;
    s_d[0]   = '0;
    cin_k[0] = sub ^ c_in;
    for (int k = 1; k < STAGES; k++) begin
      vld_d[k] = vld_q[k-1];
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      s_d[k]   = s_q[k-1];
      cin_k[k] = cy_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      part[k] = {1'b0, a_d[k][k*CHUNK +: CHUNK]} + {1'b0, b_d[k][k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, cin_k[k]};
      s_d[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
      cy_d[k] = part[k][CHUNK];
    end
    ovf_d = (a_d[STAGES-1][MSB] == b_d[STAGES-1][MSB]) &&
            (s_d[STAGES-1][MSB] != a_d[STAGES-1][MSB]);
`ifdef ADDSUB_SAT_EN
    if (ovf_d) begin
      s_d[STAGES-1] = a_d[STAGES-1][MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // NOTE: data registers are reset along with the valid bits, so the outputs read as zero right after reset.
  // NOTE: sequential state is assigned with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (!stall) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign c_out     = cy_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=16, CHUNK=4): directed vectors, back-pressure stream, mid-stream reset.
// Build with +define+ADDSUB_SAT_EN to check the saturating variant.
module tb_addsub_pipe;

`ifdef ADDSUB_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        c_in = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;

  addsub_pipe #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference from signed/unsigned integer arithmetic; returns {ovf, c_out, sum}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s);
    int sx = $signed(x);
    int sy = $signed(y);
    int ux = x;
    int uy = y;
    int r;
    logic co, ov;
    logic [15:0] res;
    r   = s ? (sx - sy - ci) : (sx + sy + ci);
    ov  = (r > 32767) || (r < -32768);
    co  = s ? (ux >= uy + ci) : (ux + uy + ci > 65535);
    res = r[15:0];
    if (SAT && ov) res = x[15] ? 16'h8000 : 16'h7FFF;
    return {ov, co, res};
  endfunction

  // Issue one op into an empty pipe, measure latency, check the result and the bubble behind it.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = v.a; b = v.b; c_in = v.cin; sub = v.sub;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_sum"}, sum, v.sum);
    check({tag, "_cout"}, c_out, v.cout);
    check({tag, "_ovf"}, ovf, v.ovf);
    @(negedge clk);
    check({tag, "_drain"}, out_valid, 1'b0);
  endtask

  vec_t vecs[11];

  initial begin
    logic [15:0] op_a [8];
    logic [15:0] op_b [8];
    logic        op_c [8];
    logic        op_s [8];
    logic [17:0] exp_q [$];
    logic [17:0] held;
    logic        prev_stall;
    int sent, got, cyc, ghost;
    vec_t v;

    vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
    vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
    vecs[5]  = '{16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0};
    vecs[6]  = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[7]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1};
    vecs[9]  = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
    vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

    // Reset for two cycles.
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", c_out, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back stream with out_ready pattern 1,0,0,1.
    for (int i = 0; i < 8; i++) begin
      op_a[i] = 16'($urandom);
      op_b[i] = 16'($urandom);
      op_c[i] = 1'($urandom_range(1));
      op_s[i] = 1'($urandom_range(1));
    end
    op_a[0] = 16'h7FF0; op_b[0] = 16'h0020; op_s[0] = 1'b0;
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; held = '0;
    while ((sent < 8 || got < 8) && cyc < 200) begin
      @(negedge clk);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (sent < 8) begin
        in_valid = 1'b1;
        a = op_a[sent]; b = op_b[sent]; c_in = op_c[sent]; sub = op_s[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        check("bp_hold_valid", out_valid, 1'b1);
        check("bp_hold_data", {ovf, c_out, sum}, held);
      end
      check("bp_in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("bp_extra_result", out_valid, 1'b0);
        else check($sformatf("bp_result%0d", got), {ovf, c_out, sum}, exp_q.pop_front());
        got++;
      end
      prev_stall = out_valid && !out_ready;
      held = {ovf, c_out, sum};
      if (in_valid && in_ready) begin
        exp_q.push_back(model(op_a[sent], op_b[sent], op_c[sent], op_s[sent]));
        sent++;
      end
      cyc++;
    end
    check("bp_results_count", got, 8);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Mid-stream reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 16'h0100 * 16'(i + 1); b = 16'h0011; c_in = 1'b0; sub = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("mr_before_valid", out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("mr_valid_drop", out_valid, 1'b0);
    check("mr_sum_clear", sum, 16'h0000);
    check("mr_in_ready", in_ready, 1'b1);
    #4 rst_n = 1'b1;
    ghost = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) ghost++;
    end
    check("mr_no_ghost", ghost, 0);
    v = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    run_vec(v, "mr_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
